// File: rtl/riscv_pc_redirect_ctrl_pkg.sv
// Shared types and helpers for the PC redirect controller.
package riscv_pc_redir_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PD   = 2'd1,
    SRC_BU   = 2'd2,
    SRC_ST   = 2'd3
  } redir_src_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } redir_state_t;

  // Alignment mask for fetch addresses: bit0 always cleared, bit1 too without RVC.
  function automatic logic [63:0] adr_mask(input int xlen, input int has_rvc);
    logic [63:0] m;
    m = '1;
    if (xlen < 64) m = (64'd1 << xlen) - 64'd1;
    m[0] = 1'b0;
    if (has_rvc == 0) m[1] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/riscv_pc_redirect_ctrl_if.sv
// Fetch-side handshake of the redirect controller.
// master: redirect controller, slave: fetch unit.
interface riscv_pc_redirect_ctrl_if #(parameter int XLEN = 32) ();
  import riscv_pc_redir_pkg::*;

  logic            redir_req_o;
  logic [XLEN-1:0] redir_pc_o;
  redir_src_t      redir_src_o;
  logic            if_redir_ack_i;
  logic            if_req_i;
  logic            if_rsp_i;
  logic            discard_o;

  modport master (
    output redir_req_o, redir_pc_o, redir_src_o, discard_o,
    input  if_redir_ack_i, if_req_i, if_rsp_i
  );

  modport slave (
    input  redir_req_o, redir_pc_o, redir_src_o, discard_o,
    output if_redir_ack_i, if_req_i, if_rsp_i
  );
endinterface

// File: rtl/riscv_fetch_inflight_cnt.sv
// Outstanding-fetch and old-path kill counters; flags responses to discard.
module riscv_fetch_inflight_cnt #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic          if_rsp_i,
  input  logic          redir_ack_i,
  output logic [CW-1:0] kill_cnt_o,
  output logic [CW-1:0] kill_cnt_nxt_o,
  output logic          discard_o
);

  logic [CW-1:0] inflight, inflight_nxt;
  logic [CW-1:0] kill_cnt;

  // Next values: an ack turns everything still in flight (minus this cycle's
  // response) into old path; otherwise old-path responses drain the kill count.
  always_comb begin
    inflight_nxt   = inflight + CW'(if_req_i) - CW'(if_rsp_i);
    kill_cnt_nxt_o = kill_cnt;
    if (redir_ack_i)
      kill_cnt_nxt_o = inflight - CW'(if_rsp_i);
    else if (if_rsp_i && kill_cnt != '0)
      kill_cnt_nxt_o = kill_cnt - CW'(1);
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight <= '0;
      kill_cnt <= '0;
    end else begin
      inflight <= inflight_nxt;
      kill_cnt <= kill_cnt_nxt_o;
    end
  end

  assign kill_cnt_o = kill_cnt;
  assign discard_o  = if_rsp_i & ((kill_cnt != '0) | redir_ack_i);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(if_req_i && inflight == CW'(MAX_INFLIGHT)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(if_rsp_i && inflight == '0));

endmodule

// File: rtl/riscv_pc_redirect_ctrl.sv
// Next-PC redirect arbiter: st > bu > pd, one registered request held until
// fetch acks it. Optional statistics counters: RV12_REDIRECT_STATS_EN.
//
// state | meaning
// IDLE  | no redirect pending, no old-path fetches outstanding
// PEND  | redirect presented to fetch, waiting for ack
// DRAIN | redirect accepted, old-path responses still to discard
module riscv_pc_redirect_ctrl import riscv_pc_redir_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] PC_INIT      = 'h200,
  parameter int              HAS_RVC      = 0,
  parameter int              MAX_INFLIGHT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            du_mode_i,
  input  logic            st_flush_i,
  input  logic [XLEN-1:0] st_nxt_pc_i,
  input  logic            bu_flush_i,
  input  logic [XLEN-1:0] bu_nxt_pc_i,
  input  logic            pd_latch_nxt_pc_i,
  input  logic [XLEN-1:0] pd_nxt_pc_i,
  riscv_pc_redirect_ctrl_if.master fif,
  output logic            busy_o
`ifdef RV12_REDIRECT_STATS_EN
  ,
  output logic [15:0]     stat_st_o,
  output logic [15:0]     stat_bu_o,
  output logic [15:0]     stat_pd_o,
  output logic [15:0]     stat_discard_o
`endif
);

  localparam int              CW       = $clog2(MAX_INFLIGHT + 1);
  localparam logic [63:0]     MASK64   = adr_mask(XLEN, HAS_RVC);
  localparam logic [XLEN-1:0] ADR_MASK = MASK64[XLEN-1:0];

  redir_state_t    state;
  logic            redir_req;
  logic [XLEN-1:0] redir_pc;
  redir_src_t      redir_src;
  logic            win_vld, pend_win_vld, ack;
  redir_src_t      win_src, pend_win_src;
  logic [XLEN-1:0] win_pc, pend_win_pc;
  logic [CW-1:0]   kill_cnt, kill_cnt_nxt;

  // Fixed-priority select; while pending, pd is wrong-path and bu cannot displace st
  always_comb begin
    win_vld = 1'b1;
    win_src = SRC_NONE;
    win_pc  = '0;
    if (st_flush_i) begin
      win_src = SRC_ST;
      win_pc  = st_nxt_pc_i;
    end else if (bu_flush_i) begin
      win_src = SRC_BU;
      win_pc  = bu_nxt_pc_i;
    end else if (pd_latch_nxt_pc_i && !du_mode_i) begin
      win_src = SRC_PD;
      win_pc  = pd_nxt_pc_i;
    end else begin
      win_vld = 1'b0;
    end
    pend_win_vld = st_flush_i | (bu_flush_i & (redir_src != SRC_ST));
    pend_win_src = st_flush_i ? SRC_ST : SRC_BU;
    pend_win_pc  = st_flush_i ? st_nxt_pc_i : bu_nxt_pc_i;
  end

  assign ack = redir_req & fif.if_redir_ack_i;

  // Redirect FSM with registered request/pc/src
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      redir_req <= 1'b0;
      redir_pc  <= PC_INIT & ADR_MASK;
      redir_src <= SRC_NONE;
    end else begin
      case (state)
        IDLE, DRAIN: begin
          if (win_vld) begin
            state     <= PEND;
            redir_req <= 1'b1;
            redir_pc  <= win_pc & ADR_MASK;
            redir_src <= win_src;
          end else if (state == DRAIN && kill_cnt_nxt == '0) begin
            state <= IDLE;
          end
        end
        PEND: begin
          if (ack) begin
            if (win_vld) begin
              redir_pc  <= win_pc & ADR_MASK;
              redir_src <= win_src;
            end else begin
              redir_req <= 1'b0;
              redir_src <= SRC_NONE;
              state     <= (kill_cnt_nxt != '0) ? DRAIN : IDLE;
            end
          end else if (pend_win_vld) begin
            redir_pc  <= pend_win_pc & ADR_MASK;
            redir_src <= pend_win_src;
          end
        end
        default: begin
          state     <= IDLE;
          redir_req <= 1'b0;
          redir_src <= SRC_NONE;
        end
      endcase
    end
  end

  riscv_fetch_inflight_cnt #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CW           (CW)
  ) u_inflight (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .if_req_i       (fif.if_req_i),
    .if_rsp_i       (fif.if_rsp_i),
    .redir_ack_i    (ack),
    .kill_cnt_o     (kill_cnt),
    .kill_cnt_nxt_o (kill_cnt_nxt),
    .discard_o      (fif.discard_o)
  );

  assign fif.redir_req_o = redir_req;
  assign fif.redir_pc_o  = redir_pc;
  assign fif.redir_src_o = redir_src;
  assign busy_o          = (state != IDLE) | (kill_cnt != '0);

`ifdef RV12_REDIRECT_STATS_EN
  // Saturating per-source ack counters and discard counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_st_o      <= '0;
      stat_bu_o      <= '0;
      stat_pd_o      <= '0;
      stat_discard_o <= '0;
    end else begin
      if (ack && redir_src == SRC_ST && stat_st_o != 16'hFFFF) stat_st_o <= stat_st_o + 16'd1;
      if (ack && redir_src == SRC_BU && stat_bu_o != 16'hFFFF) stat_bu_o <= stat_bu_o + 16'd1;
      if (ack && redir_src == SRC_PD && stat_pd_o != 16'hFFFF) stat_pd_o <= stat_pd_o + 16'd1;
      if (fif.discard_o && stat_discard_o != 16'hFFFF) stat_discard_o <= stat_discard_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_pc_redirect_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against an
// epoch-tagged fetch-queue reference model.
module tb_riscv_pc_redirect_ctrl;
  import riscv_pc_redir_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        du_mode, st_flush, bu_flush, pd_latch;
  logic [31:0] st_pc, bu_pc, pd_pc;
  logic        busy;
`ifdef RV12_REDIRECT_STATS_EN
  logic [15:0] stat_st, stat_bu, stat_pd, stat_discard;
`endif

  riscv_pc_redirect_ctrl_if #(.XLEN(32)) fif ();

  always #5 clk_i = ~clk_i;

  riscv_pc_redirect_ctrl #(
    .XLEN(32), .PC_INIT(32'h200), .HAS_RVC(0), .MAX_INFLIGHT(4)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .du_mode_i         (du_mode),
    .st_flush_i        (st_flush),
    .st_nxt_pc_i       (st_pc),
    .bu_flush_i        (bu_flush),
    .bu_nxt_pc_i       (bu_pc),
    .pd_latch_nxt_pc_i (pd_latch),
    .pd_nxt_pc_i       (pd_pc),
    .fif               (fif),
    .busy_o            (busy)
`ifdef RV12_REDIRECT_STATS_EN
    ,
    .stat_st_o         (stat_st),
    .stat_bu_o         (stat_bu),
    .stat_pd_o         (stat_pd),
    .stat_discard_o    (stat_discard)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one pending redirect slot, and a FIFO of outstanding
  // fetches each tagged with the redirect epoch it was issued under.
  bit          m_pend;
  logic [31:0] m_pc;
  logic [1:0]  m_src;
  int          m_epoch;
  int          m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    bit b;
    b = m_pend;
    foreach (m_q[i]) if (m_q[i] != m_epoch) b = 1'b1;
    return b;
  endfunction

  task automatic m_reset();
    m_pend  = 1'b0;
    m_pc    = 32'h200;
    m_src   = SRC_NONE;
    m_epoch = 0;
    m_q.delete();
  endtask

  task automatic drive_idle();
    du_mode = 0; st_flush = 0; bu_flush = 0; pd_latch = 0;
    st_pc = 0; bu_pc = 0; pd_pc = 0;
    fif.if_redir_ack_i = 0; fif.if_req_i = 0; fif.if_rsp_i = 0;
  endtask

  task automatic step(input bit s, input logic [31:0] sp, input bit b, input logic [31:0] bp,
                      input bit p, input logic [31:0] pp, input bit d,
                      input bit a, input bit rq, input bit rs);
    bit          ack_now, disc, wv;
    int          ne;
    logic [1:0]  ws;
    logic [31:0] wp;
    @(negedge clk_i);
    st_flush = s; st_pc = sp; bu_flush = b; bu_pc = bp;
    pd_latch = p; pd_pc = pp; du_mode = d;
    fif.if_redir_ack_i = a; fif.if_req_i = rq; fif.if_rsp_i = rs;
    #1;
    ack_now = m_pend && a;
    ne      = m_epoch + (ack_now ? 1 : 0);
    disc    = rs && (m_q.size() > 0) && (m_q[0] != ne);
    chk("redir_req", {31'd0, fif.redir_req_o}, {31'd0, m_pend});
    chk("redir_pc", fif.redir_pc_o, m_pc);
    chk("redir_src", {30'd0, fif.redir_src_o}, {30'd0, m_src});
    chk("discard", {31'd0, fif.discard_o}, {31'd0, disc});
    chk("busy", {31'd0, busy}, {31'd0, m_busy()});
    @(posedge clk_i);
    wv = 1'b1; ws = SRC_NONE; wp = '0;
    if (s)            begin ws = SRC_ST; wp = sp; end
    else if (b)       begin ws = SRC_BU; wp = bp; end
    else if (p && !d) begin ws = SRC_PD; wp = pp; end
    else wv = 1'b0;
    if (!m_pend) begin
      if (wv) begin m_pend = 1; m_src = ws; m_pc = wp & ~32'h3; end
    end else if (ack_now) begin
      if (wv) begin m_src = ws; m_pc = wp & ~32'h3; end
      else begin m_pend = 0; m_src = SRC_NONE; end
    end else if (s) begin
      m_src = SRC_ST; m_pc = sp & ~32'h3;
    end else if (b && m_src != SRC_ST) begin
      m_src = SRC_BU; m_pc = bp & ~32'h3;
    end
    if (rs && m_q.size() > 0) void'(m_q.pop_front());
    m_epoch = ne;
    if (rq) m_q.push_back(ne);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Async reset between clock edges; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    drive_idle();
    #1;
    chk("rst_req", {31'd0, fif.redir_req_o}, 32'd0);
    chk("rst_pc", fif.redir_pc_o, 32'h200);
    chk("rst_src", {30'd0, fif.redir_src_o}, {30'd0, SRC_NONE});
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_discard", {31'd0, fif.discard_o}, 32'd0);
    m_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    bit s, b, p, d, a, rq, rs;
    drive_idle();
    m_reset();
    do_reset();
    idle(3);

    // st/bu/pd together: st wins; bu cannot displace pending st; ack -> idle
    step(1, 32'h1000, 1, 32'h2000, 1, 32'h3000, 0, 0, 0, 0);
    step(0, 0, 1, 32'h2000, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);

    // pending pd overwritten by bu; pd in debug mode ignored; masking of low bits
    step(0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0);
    step(0, 0, 1, 32'h43, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h99, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'h90, 1, 0, 0, 0);
    idle(2);

    // three old fetches, ack with one rsp and a new fetch; two discards then keep
    step(0, 0, 1, 32'h100, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // new bu during drain, ack after one rsp: reload without double count
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 32'h600, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // reset in the middle of a pending redirect
    step(1, 32'h700, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset();
    idle(2);

    // random traffic obeying the fetch protocol
    for (int i = 0; i < 4000; i++) begin
      s  = ($urandom_range(0, 15) == 0);
      b  = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 4) == 0);
      d  = ($urandom_range(0, 7) == 0);
      a  = m_pend && ($urandom_range(0, 2) == 0);
      rq = (m_q.size() < 4) && ($urandom_range(0, 1) == 1);
      rs = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      step(s, $urandom, b, $urandom, p, $urandom, d, a, rq, rs);
    end
    idle(6);

`ifdef RV12_REDIRECT_STATS_EN
    do_reset();
    step(0, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 1, 32'h40, 0, 1, 0, 0);
    do_reset();
    chk("stat_pd_rst", {16'd0, stat_pd}, 32'd0);
    step(0, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 1, 32'h40, 0, 1, 0, 0);
    @(negedge clk_i);
    #1;
    chk("stat_pd_sat", {16'd0, stat_pd}, 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
